l1_icache: RTL and testbench

L1_ICACHE -- requirements
Module: l1_icache

---
 rtl/common.sv | 14 +
 rtl/icache_data_ram.sv | 24 ++
 rtl/l1_icache.sv | 169 ++++++++++++++++
 tb/tb_l1_icache.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared types and default geometry for the L1 instruction cache.
package common_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MISS_REQ = 2'd1,
    REFILL   = 2'd2,
    RESP     = 2'd3
  } icache_state_t;

  localparam int DEF_NUM_LINES  = 64;
  localparam int DEF_LINE_WORDS = 4;

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data array: one write port, one synchronous read port.
module icache_data_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/l1_icache.sv
// Direct-mapped L1 instruction cache with line refill from l2 and flush support.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; valid never waits on ready.
module l1_icache
  import common_pkg::*;
#(
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [31:0]   req_addr,
  output logic          req_ready,
  input  logic          flush,
  output logic          resp_valid,
  output logic [31:0]   resp_inst,
  output logic          resp_error,
  output logic          mem_req_valid,
  output logic [31:0]   mem_req_addr,
  input  logic          mem_req_ready,
  input  logic          mem_resp_valid,
  input  logic [31:0]   mem_resp_data,
  output icache_state_t dbg_state
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TW = 32 - 2 - WB - IB;
  localparam int AW = IB + WB;

  icache_state_t        state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]        tag_q [NUM_LINES];
  logic [31:2]          req_q, req_d;
  logic [WB-1:0]        beat_q, beat_d;
  logic                 kill_q, kill_d;
  logic                 hit_resp_q, hit_resp_d;
  logic                 err_resp_q, err_resp_d;
  logic [31:0]          word_q, word_d;

  logic          accept, misaligned, lookup_hit, last_beat;
  logic          ram_we, tag_we;
  logic [31:0]   ram_rdata;
  logic [TW-1:0] in_tag, rq_tag;
  logic [IB-1:0] in_idx, rq_idx;
  logic [WB-1:0] in_word, rq_word;

  assign in_tag  = req_addr[31 -: TW];
  assign in_idx  = req_addr[2+WB +: IB];
  assign in_word = req_addr[2 +: WB];
  assign rq_tag  = req_q[31 -: TW];
  assign rq_idx  = req_q[2+WB +: IB];
  assign rq_word = req_q[2 +: WB];

  assign req_ready  = (state_q == IDLE) && !flush;
  assign accept     = req_valid && req_ready;
  assign misaligned = (req_addr[1:0] != 2'b00);
  assign lookup_hit = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
  assign last_beat  = (beat_q == WB'(LINE_WORDS - 1));

  // A flush in the response cycle swallows the pulse.
  assign resp_valid    = (hit_resp_q || err_resp_q || (state_q == RESP)) && !flush;
  assign resp_error    = err_resp_q && !flush;
  assign resp_inst     = (state_q == RESP) ? word_q : (hit_resp_q ? ram_rdata : '0);
  assign mem_req_valid = (state_q == MISS_REQ);
  assign mem_req_addr  = {req_q[31:2+WB], {(WB+2){1'b0}}};
  assign dbg_state     = state_q;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    req_d      = req_q;
    beat_d     = beat_q;
    kill_d     = kill_q;
    word_d     = word_q;
    hit_resp_d = 1'b0;
    err_resp_d = 1'b0;
    ram_we     = 1'b0;
    tag_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d = req_addr[31:2];
          if (misaligned) begin
            err_resp_d = 1'b1;
          end else if (lookup_hit) begin
            hit_resp_d = 1'b1;
          end else begin
            state_d = MISS_REQ;
            kill_d  = 1'b0;
          end
        end
      end
      MISS_REQ: begin
        if (mem_req_ready) begin
          state_d = REFILL;
          beat_d  = '0;
        end
      end
      REFILL: begin
        if (mem_resp_valid) begin
          ram_we = 1'b1;
          beat_d = beat_q + 1'b1;
          // Keep the requested word aside so RESP needs no extra RAM read.
          if (beat_q == rq_word) word_d = mem_resp_data;
          if (last_beat) begin
            if (kill_q || flush) begin
              state_d = IDLE;
            end else begin
              tag_we          = 1'b1;
              valid_d[rq_idx] = 1'b1;
              state_d         = RESP;
            end
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush) begin
      valid_d = '0;
      kill_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      req_q      <= '0;
      beat_q     <= '0;
      kill_q     <= 1'b0;
      word_q     <= '0;
      hit_resp_q <= 1'b0;
      err_resp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
      beat_q     <= beat_d;
      kill_q     <= kill_d;
      word_q     <= word_d;
      hit_resp_q <= hit_resp_d;
      err_resp_q <= err_resp_d;
    end
  end

  // Tag storage is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[rq_idx] <= rq_tag;
  end

  icache_data_ram #(
    .DEPTH (NUM_LINES * LINE_WORDS),
    .AW    (AW)
  ) u_data_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr ({rq_idx, beat_q}),
    .wdata (mem_resp_data),
    .raddr ({in_idx, in_word}),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_l1_icache.sv
// Directed bench for l1_icache: scoreboard of expected responses plus inline timing checks.
module tb_l1_icache;
  import common_pkg::*;

  localparam int LW = 4;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic [31:0]   req_addr;
  logic          req_ready;
  logic          flush;
  logic          resp_valid;
  logic [31:0]   resp_inst;
  logic          resp_error;
  logic          mem_req_valid;
  logic [31:0]   mem_req_addr;
  logic          mem_req_ready;
  logic          mem_resp_valid;
  logic [31:0]   mem_resp_data;
  icache_state_t dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int bus_cnt  = 0;
  int bus_snap;
  logic [32:0] exp_q[$];
  logic [32:0] exp_v;

  l1_icache #(.NUM_LINES(64), .LINE_WORDS(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .flush          (flush),
    .resp_valid     (resp_valid),
    .resp_inst      (resp_inst),
    .resp_error     (resp_error),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .dbg_state      (dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every response pulse must match the head of exp_q
  always @(negedge clk) begin
    if (rst && mem_req_valid && mem_req_ready) bus_cnt++;
    if (rst && resp_valid) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL resp_unexpected: observed %h expected no response", {resp_error, resp_inst});
      end
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        assert ({resp_error, resp_inst} === exp_v) else begin
          n_err++;
          $error("FAIL resp_data: observed %h expected %h", {resp_error, resp_inst}, exp_v);
        end
      end
    end
  end

  // driver: present one request and hold it until accepted
  task automatic issue_req(input logic [31:0] addr);
    int waited;
    waited    = 0;
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    while (!req_ready && waited < 20) begin
      step();
      waited++;
    end
    check("req_accepted", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // driver: act as l2 for one line refill
  task automatic serve_refill(input logic [31:0] exp_addr, input logic [31:0] base,
                              input int stall, input int flush_beat, input bit expect_resp);
    int waited;
    waited = 0;
    while (!mem_req_valid && waited < 20) begin
      step();
      waited++;
    end
    check("mem_req_seen", {31'd0, mem_req_valid}, 32'd1);
    check("mem_req_addr", mem_req_addr, exp_addr);
    for (int s = 0; s < stall; s++) begin
      step();
      check("mem_req_hold_valid", {31'd0, mem_req_valid}, 32'd1);
      check("mem_req_hold_addr", mem_req_addr, exp_addr);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("mem_req_drop", {31'd0, mem_req_valid}, 32'd0);
    for (int b = 0; b < LW; b++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = base + 32'(b);
      flush          = (b == flush_beat);
      step();
    end
    mem_resp_valid = 1'b0;
    flush          = 1'b0;
    check("resp_after_last_beat", {31'd0, resp_valid}, {31'd0, expect_resp});
    step();
    check("resp_single_cycle", {31'd0, resp_valid}, 32'd0);
    check("idle_after_refill", 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    rst            = 1'b0;
    req_valid      = 1'b0;
    req_addr       = '0;
    flush          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;

    // reset state
    repeat (3) step();
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    check("rst_resp_inst", resp_inst, 32'd0);
    check("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_mem_req_addr", mem_req_addr, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    step();
    check("req_ready_after_reset", {31'd0, req_ready}, 32'd1);

    // cold miss
    exp_q.push_back({1'b0, 32'h0000_00A0});
    issue_req(32'h0000_0010);
    check("miss_no_early_resp", {31'd0, resp_valid}, 32'd0);
    check("miss_req_ready_low", {31'd0, req_ready}, 32'd0);
    serve_refill(32'h0000_0010, 32'h0000_00A0, 2, -1, 1'b1);

    // single hit
    bus_snap = bus_cnt;
    exp_q.push_back({1'b0, 32'h0000_00A3});
    issue_req(32'h0000_001C);
    check("hit_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("hit_no_bus", {31'd0, mem_req_valid}, 32'd0);
    step();
    check("hit_resp_single", {31'd0, resp_valid}, 32'd0);

    // back-to-back hits, one response per cycle
    req_valid = 1'b1;
    for (int i = 0; i < LW; i++) begin
      req_addr = 32'h0000_0010 + 32'(4 * i);
      exp_q.push_back({1'b0, 32'h0000_00A0 + 32'(i)});
      step();
      check("b2b_resp_valid", {31'd0, resp_valid}, 32'd1);
    end
    req_valid = 1'b0;
    step();
    check("b2b_bus_quiet", 32'(bus_cnt), 32'(bus_snap));

    // conflict: same index, different tag
    exp_q.push_back({1'b0, 32'h0000_00B0});
    issue_req(32'h0000_0410);
    serve_refill(32'h0000_0410, 32'h0000_00B0, 0, -1, 1'b1);
    exp_q.push_back({1'b0, 32'h0000_00C0});
    issue_req(32'h0000_0010);
    serve_refill(32'h0000_0010, 32'h0000_00C0, 1, -1, 1'b1);

    // misaligned
    bus_snap = bus_cnt;
    exp_q.push_back({1'b1, 32'h0000_0000});
    issue_req(32'h0000_0012);
    check("misaligned_valid", {31'd0, resp_valid}, 32'd1);
    check("misaligned_error", {31'd0, resp_error}, 32'd1);
    check("misaligned_inst", resp_inst, 32'd0);
    check("misaligned_state", 32'(dbg_state), 32'(IDLE));
    step();
    check("misaligned_no_bus", {31'd0, mem_req_valid}, 32'd0);
    check("misaligned_bus_cnt", 32'(bus_cnt), 32'(bus_snap));

    // flush suppresses a hit response due this cycle
    issue_req(32'h0000_0014);
    flush = 1'b1;
    #1;
    check("flush_suppress_valid", {31'd0, resp_valid}, 32'd0);
    check("flush_req_ready_low", {31'd0, req_ready}, 32'd0);
    step();
    flush = 1'b0;

    // flush during beat 2 of a refill: drained, no response
    issue_req(32'h0000_0010);
    serve_refill(32'h0000_0010, 32'h0000_00F0, 0, 2, 1'b0);
    repeat (2) step();
    check("flushed_refill_quiet", {31'd0, resp_valid}, 32'd0);
    exp_q.push_back({1'b0, 32'h0000_00D0});
    issue_req(32'h0000_0010);
    serve_refill(32'h0000_0010, 32'h0000_00D0, 0, -1, 1'b1);

    // asynchronous reset in the middle of a refill
    issue_req(32'h0000_0030);
    check("rst_test_miss", {31'd0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0EE0;
    step();
    mem_resp_valid = 1'b0;
    check("rst_test_in_refill", 32'(dbg_state), 32'(REFILL));
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("async_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'(IDLE));
    step();
    rst = 1'b1;
    step();
    check("req_ready_after_async_rst", {31'd0, req_ready}, 32'd1);
    exp_q.push_back({1'b0, 32'h0000_00E0});
    issue_req(32'h0000_0010);
    serve_refill(32'h0000_0010, 32'h0000_00E0, 0, -1, 1'b1);

    repeat (3) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
